hpdcache_mem_read_sched: RTL and testbench
==========================================

// Module: hpdcache_mem_read_sched
// PURPOSE
//  Shares one memory read-request channel (feeding the mem-to-AXI read adapter) between N_REQ
//  requesters, e.g. I$ refill and D$ miss. Round-robin arbitration, gated per requester by an
//  outstanding-transaction credit limit and by ID-table availability. Records the owner of each
//  issued ID and steers read responses (id/last) back to that owner; payload bypasses this block.
// PARAMETERS
//  N_REQ       2   number of requesters (>=2)
//  ID_WIDTH    4   transaction ID width; ID table has 2**ID_WIDTH entries
//  MAX_OUTST   4   max in-flight transactions per requester (>=1)
//  ADDR_WIDTH  64  request address width
//  LEN_WIDTH   8   burst length field width
// PORTS
//  clk_i             in   1                  clock, rising edge
//  rst_i             in   1                  reset, asynchronous, active-high
//  req_valid_i       in   N_REQ              per-requester request valid
//  req_ready_o       out  N_REQ              per-requester grant/accept
//  req_addr_i        in   N_REQ*ADDR_WIDTH   request address, requester i at slice i
//  req_len_i         in   N_REQ*LEN_WIDTH    burst length-1
//  req_id_i          in   N_REQ*ID_WIDTH     transaction ID chosen by requester
//  mem_req_valid_o   out  1                  registered request to read adapter
//  mem_req_ready_i   in   1                  read adapter accepts
//  mem_req_addr_o    out  ADDR_WIDTH         registered address
//  mem_req_len_o     out  LEN_WIDTH          registered length
//  mem_req_id_o      out  ID_WIDTH           registered ID
//  mem_resp_valid_i  in   1                  read response beat valid
//  mem_resp_ready_o  out  1                  read response beat accepted
//  mem_resp_id_i     in   ID_WIDTH           response ID
//  mem_resp_last_i   in   1                  last beat of burst
//  resp_valid_o      out  N_REQ              one-hot response-beat valid to owner
//  resp_ready_i      in   N_REQ              owner ready
//  outst_cnt_o       out  N_REQ*$clog2(MAX_OUTST+1)  in-flight count per requester
//  unknown_id_err_o  out  1                  sticky: response hit an unallocated ID
// BEHAVIOUR
//  Reset (async, rst_i=1): out reg empty (mem_req_valid_o=0), ID table all free, counts 0,
//   RR pointer 0, unknown_id_err_o=0; req_ready_o and resp_valid_o follow comb rules (0 while empty/idle).
//  Eligible(i) = req_valid_i[i] & cnt[i]<MAX_OUTST & table[req_id_i[i]] free (registered state).
//  Output register load enable LD = ~mem_req_valid_o | mem_req_ready_i (full throughput, 1/cycle).
//  Arbiter: when LD, winner = first eligible requester scanning ptr, ptr+1, ... mod N_REQ;
//   req_ready_o[winner]=1 (others 0); same edge: out reg <= winner's addr/len/id, valid<=1,
//   table[id] <= {busy, owner=winner}, cnt[winner]++, ptr <= winner+1 mod N_REQ.
//   No eligible requester while LD: valid<=0, ptr unchanged.
//  Request latency: grant cycle -> mem_req_valid_o next cycle; held stable until mem_req_ready_i.
//  Two requesters presenting the same free ID in one cycle: only the winner allocates; the loser
//   sees the ID busy next cycle.
//  Response steering (combinational): hit = table[mem_resp_id_i] busy; owner = its owner field.
//   hit: resp_valid_o[owner]=mem_resp_valid_i, mem_resp_ready_o=resp_ready_i[owner].
//   miss: resp_valid_o=0, mem_resp_ready_o=1 (beat dropped), unknown_id_err_o set on valid.
//  Retire: on mem_resp_valid_i & mem_resp_ready_o & mem_resp_last_i & hit -> table entry freed,
//   cnt[owner]--. Freed ID/credit is usable from the following cycle only.
//  Simultaneous grant and retire for the same requester: cnt net unchanged; grant checks pre-edge cnt.
//  Counters saturate-checked: increment never exceeds MAX_OUTST; decrement never below 0
//   (assertion-protected, not expected to fire).
//  unknown_id_err_o clears only on reset.
// TESTING
//  1 req0 and req1 valid continuously, distinct IDs, ready_i=1 -> grants alternate 0,1,0,1; one mem req/cycle.
//  2 req0 issues MAX_OUTST=4 IDs 0..3, no responses -> 5th req0 stalled, req1 still granted; one last beat ID2 -> req0 granted the cycle after.
//  3 req0 and req1 both present ID 5 at ptr=0 -> req0 granted; req1 waits until ID5 last beat retired, then granted.
//  4 mem_req_ready_i=0 for 3 cycles -> mem_req_addr/len/id stable, no req_ready_o pulses; ready=1 -> next grant same cycle.
//  5 4-beat response ID1 owned by req1, resp_ready_i[1] low on beat 2 -> mem_resp_ready_o low that cycle; cnt[1]-- only after beat 4.
//  6 response with unallocated ID 9 -> beat consumed, no resp_valid_o, unknown_id_err_o=1 until rst_i; rst_i mid-burst -> all state cleared.

Source files
------------

// File: rtl/hpdcache_mem_read_sched_if.sv
// Bundle of requester-side and memory-side handshake signals around the read scheduler.
// The scheduler attaches through the slave modport; requesters and the read adapter use master.
interface hpdcache_mem_read_sched_if #(
  parameter int N_REQ      = 2,
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 64,
  parameter int LEN_WIDTH  = 8
);
  logic [N_REQ-1:0]            req_valid_i;
  logic [N_REQ-1:0]            req_ready_o;
  logic [N_REQ*ADDR_WIDTH-1:0] req_addr_i;
  logic [N_REQ*LEN_WIDTH-1:0]  req_len_i;
  logic [N_REQ*ID_WIDTH-1:0]   req_id_i;

  logic                        mem_req_valid_o;
  logic                        mem_req_ready_i;
  logic [ADDR_WIDTH-1:0]       mem_req_addr_o;
  logic [LEN_WIDTH-1:0]        mem_req_len_o;
  logic [ID_WIDTH-1:0]         mem_req_id_o;

  logic                        mem_resp_valid_i;
  logic                        mem_resp_ready_o;
  logic [ID_WIDTH-1:0]         mem_resp_id_i;
  logic                        mem_resp_last_i;
  logic [N_REQ-1:0]            resp_valid_o;
  logic [N_REQ-1:0]            resp_ready_i;

  modport slave (
    input  req_valid_i, req_addr_i, req_len_i, req_id_i,
    output req_ready_o,
    output mem_req_valid_o, mem_req_addr_o, mem_req_len_o, mem_req_id_o,
    input  mem_req_ready_i,
    input  mem_resp_valid_i, mem_resp_id_i, mem_resp_last_i, resp_ready_i,
    output mem_resp_ready_o, resp_valid_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_len_i, req_id_i,
    input  req_ready_o,
    input  mem_req_valid_o, mem_req_addr_o, mem_req_len_o, mem_req_id_o,
    output mem_req_ready_i,
    output mem_resp_valid_i, mem_resp_id_i, mem_resp_last_i, resp_ready_i,
    input  mem_resp_ready_o, resp_valid_o
  );
endinterface

// File: rtl/hpdcache_mem_read_sched.sv
// Round-robin read-request scheduler with per-requester credits and an ID ownership table
// used to steer response beats back to the requester that issued the ID.
module hpdcache_mem_read_sched #(
  parameter int N_REQ      = 2,
  parameter int ID_WIDTH   = 4,
  parameter int MAX_OUTST  = 4,
  parameter int ADDR_WIDTH = 64,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  hpdcache_mem_read_sched_if.slave               bus,
  output logic [N_REQ*$clog2(MAX_OUTST+1)-1:0]   outst_cnt_o,
  output logic                                   unknown_id_err_o
);
  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  localparam int N_ID  = 2 ** ID_WIDTH;
  localparam int OWN_W = $clog2(N_REQ);

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [OWN_W-1:0] own_t;

  localparam cnt_t CNT_MAX = cnt_t'(MAX_OUTST);

  function automatic cnt_t cnt_next(cnt_t cnt, logic inc, logic dec);
    cnt_t res;
    res = cnt;
    if (inc && !dec && (cnt != CNT_MAX)) res = cnt + cnt_t'(1);
    else if (dec && !inc && (cnt != '0)) res = cnt - cnt_t'(1);
    return res;
  endfunction

  function automatic own_t ptr_inc(own_t p);
    return (p == own_t'(N_REQ - 1)) ? '0 : p + own_t'(1);
  endfunction

  logic [N_ID-1:0]       r_busy;
  own_t                  r_owner [N_ID];
  cnt_t                  r_cnt   [N_REQ];
  own_t                  r_ptr;
  logic                  r_err;
  logic                  r_vld_p1;
  logic [ADDR_WIDTH-1:0] r_addr_p1;
  logic [LEN_WIDTH-1:0]  r_len_p1;
  logic [ID_WIDTH-1:0]   r_id_p1;

  logic [ID_WIDTH-1:0]   w_req_id [N_REQ];
  logic [N_REQ-1:0]      w_elig;
  logic                  w_ld;
  logic                  w_found;
  logic                  w_grant;
  own_t                  w_win;
  logic [ID_WIDTH-1:0]   w_win_id;
  logic [ADDR_WIDTH-1:0] w_win_addr;
  logic [LEN_WIDTH-1:0]  w_win_len;
  logic                  w_hit;
  own_t                  w_owner;
  logic                  w_mresp_rdy;
  logic                  w_retire;

  // Eligibility uses only registered credit/table state; frees land next cycle.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      w_req_id[i] = bus.req_id_i[i*ID_WIDTH +: ID_WIDTH];
      w_elig[i]   = bus.req_valid_i[i] && (r_cnt[i] < CNT_MAX) && !r_busy[w_req_id[i]];
    end
  end

  always_comb begin
    own_t idx;
    idx     = r_ptr;
    w_found = 1'b0;
    w_win   = r_ptr;
    for (int k = 0; k < N_REQ; k++) begin
      if (!w_found && w_elig[idx]) begin
        w_found = 1'b1;
        w_win   = idx;
      end
      idx = ptr_inc(idx);
    end
  end

  assign w_ld       = !r_vld_p1 || bus.mem_req_ready_i;
  assign w_grant    = w_ld && w_found;
  assign w_win_id   = bus.req_id_i[int'(w_win)*ID_WIDTH +: ID_WIDTH];
  assign w_win_addr = bus.req_addr_i[int'(w_win)*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_win_len  = bus.req_len_i[int'(w_win)*LEN_WIDTH +: LEN_WIDTH];

  always_comb begin
    bus.req_ready_o = '0;
    if (w_grant) bus.req_ready_o[w_win] = 1'b1;
  end

  // Beats with an unallocated ID are swallowed so the adapter never stalls on them.
  assign w_hit       = r_busy[bus.mem_resp_id_i];
  assign w_owner     = r_owner[bus.mem_resp_id_i];
  assign w_mresp_rdy = w_hit ? bus.resp_ready_i[w_owner] : 1'b1;
  assign w_retire    = bus.mem_resp_valid_i && w_mresp_rdy && bus.mem_resp_last_i && w_hit;

  always_comb begin
    bus.resp_valid_o = '0;
    if (w_hit) bus.resp_valid_o[w_owner] = bus.mem_resp_valid_i;
  end

  assign bus.mem_resp_ready_o = w_mresp_rdy;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_vld_p1 <= 1'b0;
      r_busy   <= '0;
      r_ptr    <= '0;
      r_err    <= 1'b0;
      for (int i = 0; i < N_REQ; i++) r_cnt[i] <= '0;
    end else begin
      if (w_ld) r_vld_p1 <= w_grant;
      if (w_grant) r_ptr <= ptr_inc(w_win);
      if (w_retire) r_busy[bus.mem_resp_id_i] <= 1'b0;
      if (w_grant) r_busy[w_win_id] <= 1'b1;
      for (int i = 0; i < N_REQ; i++) begin
        r_cnt[i] <= cnt_next(r_cnt[i], w_grant && (w_win == own_t'(i)),
                             w_retire && (w_owner == own_t'(i)));
      end
      if (bus.mem_resp_valid_i && !w_hit) r_err <= 1'b1;
    end
  end

  // ---- stage p1: request output register ----
  always_ff @(posedge clk_i) begin
    if (w_grant) begin
      r_addr_p1         <= w_win_addr;
      r_len_p1          <= w_win_len;
      r_id_p1           <= w_win_id;
      r_owner[w_win_id] <= w_win;
    end
  end

  assign bus.mem_req_valid_o = r_vld_p1;
  assign bus.mem_req_addr_o  = r_addr_p1;
  assign bus.mem_req_len_o   = r_len_p1;
  assign bus.mem_req_id_o    = r_id_p1;
  assign unknown_id_err_o    = r_err;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) outst_cnt_o[i*CNT_W +: CNT_W] = r_cnt[i];
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_cnt_chk
    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
      !(w_grant && (w_win == own_t'(g)) && !(w_retire && (w_owner == own_t'(g)))
        && (r_cnt[g] == CNT_MAX)));
    a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
      !(w_retire && (w_owner == own_t'(g)) && !(w_grant && (w_win == own_t'(g)))
        && (r_cnt[g] == '0)));
  end
endmodule

// File: tb/tb_hpdcache_mem_read_sched.sv
// Bench for the read scheduler: directed scenarios with literal expectations, then random
// traffic, all compared each cycle against a table/credit reference model.
module tb_hpdcache_mem_read_sched;
  localparam int N_REQ      = 2;
  localparam int ID_WIDTH   = 4;
  localparam int MAX_OUTST  = 4;
  localparam int ADDR_WIDTH = 64;
  localparam int LEN_WIDTH  = 8;
  localparam int CNT_W      = 3;
  localparam int N_ID       = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hpdcache_mem_read_sched_if #(.N_REQ(N_REQ), .ID_WIDTH(ID_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
                               .LEN_WIDTH(LEN_WIDTH)) bus_if ();
  logic [N_REQ*CNT_W-1:0] outst_cnt;
  logic                   err;

  hpdcache_mem_read_sched #(.N_REQ(N_REQ), .ID_WIDTH(ID_WIDTH), .MAX_OUTST(MAX_OUTST),
                            .ADDR_WIDTH(ADDR_WIDTH), .LEN_WIDTH(LEN_WIDTH)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus_if),
    .outst_cnt_o(outst_cnt), .unknown_id_err_o(err)
  );

  int n_chk = 0;
  int n_fail = 0;

  // reference model state
  bit          m_busy  [N_ID];
  int          m_owner [N_ID];
  int          m_cnt   [N_REQ];
  int          m_ptr;
  bit          m_vld;
  logic [63:0] m_addr;
  logic [7:0]  m_len;
  logic [3:0]  m_id;
  bit          m_err;
  bit          e_ld, e_found, e_hit, e_mresp_rdy;
  int          e_win, e_owner;

  // random responder
  int rq[$];
  bit ra_active;
  int ra_id, ra_beats;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rid(int i);
    return int'(bus_if.req_id_i[i*ID_WIDTH +: ID_WIDTH]);
  endfunction

  function automatic int dut_cnt(int i);
    return int'(outst_cnt[i*CNT_W +: CNT_W]);
  endfunction

  task automatic drive_req(int i, bit v, int id, logic [63:0] a, logic [7:0] l);
    bus_if.req_valid_i[i]                    = v;
    bus_if.req_id_i[i*ID_WIDTH +: ID_WIDTH]  = id[3:0];
    bus_if.req_addr_i[i*ADDR_WIDTH +: 64]    = a;
    bus_if.req_len_i[i*LEN_WIDTH +: 8]       = l;
  endtask

  task automatic drive_resp(bit v, int id, bit last);
    bus_if.mem_resp_valid_i = v;
    bus_if.mem_resp_id_i    = id[3:0];
    bus_if.mem_resp_last_i  = last;
  endtask

  task automatic model_reset();
    for (int j = 0; j < N_ID; j++) begin m_busy[j] = 0; m_owner[j] = 0; end
    for (int i = 0; i < N_REQ; i++) m_cnt[i] = 0;
    m_ptr = 0; m_vld = 0; m_err = 0;
    m_addr = '0; m_len = '0; m_id = '0;
    rq.delete();
    ra_active = 0;
  endtask

  // Evaluate expected combinational outputs from model state and current inputs, compare all.
  task automatic settle();
    logic [1:0] exp_ready, exp_rv;
    int idx, rid_resp;
    #2;
    e_ld    = !m_vld || bus_if.mem_req_ready_i;
    e_found = 0;
    e_win   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (m_ptr + k) % N_REQ;
      if (!e_found && bus_if.req_valid_i[idx] && m_cnt[idx] < MAX_OUTST && !m_busy[rid(idx)]) begin
        e_found = 1;
        e_win   = idx;
      end
    end
    exp_ready = '0;
    if (e_ld && e_found) exp_ready[e_win] = 1'b1;
    rid_resp    = int'(bus_if.mem_resp_id_i);
    e_hit       = m_busy[rid_resp];
    e_owner     = m_owner[rid_resp];
    e_mresp_rdy = e_hit ? bus_if.resp_ready_i[e_owner] : 1'b1;
    exp_rv      = '0;
    if (e_hit) exp_rv[e_owner] = bus_if.mem_resp_valid_i;
    chk("req_ready", 64'(bus_if.req_ready_o), 64'(exp_ready));
    chk("mem_req_valid", 64'(bus_if.mem_req_valid_o), 64'(m_vld));
    if (m_vld) begin
      chk("mem_req_addr", bus_if.mem_req_addr_o, m_addr);
      chk("mem_req_len", 64'(bus_if.mem_req_len_o), 64'(m_len));
      chk("mem_req_id", 64'(bus_if.mem_req_id_o), 64'(m_id));
    end
    chk("resp_valid", 64'(bus_if.resp_valid_o), 64'(exp_rv));
    chk("mem_resp_ready", 64'(bus_if.mem_resp_ready_o), 64'(e_mresp_rdy));
    for (int i = 0; i < N_REQ; i++) chk("outst_cnt", 64'(dut_cnt(i)), 64'(m_cnt[i]));
    chk("unknown_id_err", 64'(err), 64'(m_err));
  endtask

  task automatic tick();
    bit grant, retire;
    int wid, rr;
    @(posedge clk);
    if (!rst) begin
      grant  = e_ld && e_found;
      rr     = int'(bus_if.mem_resp_id_i);
      retire = bus_if.mem_resp_valid_i && e_mresp_rdy && bus_if.mem_resp_last_i && e_hit;
      if (m_vld && bus_if.mem_req_ready_i) rq.push_back(int'(m_id));
      if (ra_active && bus_if.mem_resp_valid_i && e_mresp_rdy) begin
        ra_beats--;
        if (ra_beats == 0) ra_active = 0;
      end
      if (bus_if.mem_resp_valid_i && !e_hit) m_err = 1;
      if (retire) begin m_busy[rr] = 0; m_cnt[e_owner]--; end
      if (grant) begin
        wid           = rid(e_win);
        m_busy[wid]   = 1;
        m_owner[wid]  = e_win;
        m_cnt[e_win]++;
        m_vld  = 1;
        m_addr = bus_if.req_addr_i[e_win*ADDR_WIDTH +: 64];
        m_len  = bus_if.req_len_i[e_win*LEN_WIDTH +: 8];
        m_id   = wid[3:0];
        m_ptr  = (e_win + 1) % N_REQ;
      end else if (e_ld) begin
        m_vld = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    settle();
    chk("rst_mem_req_valid", 64'(bus_if.mem_req_valid_o), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_cnt", 64'(outst_cnt), 64'd0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int n0, n1;
    bus_if.req_valid_i = '0; bus_if.req_addr_i = '0; bus_if.req_len_i = '0; bus_if.req_id_i = '0;
    bus_if.mem_req_ready_i = 1'b1; bus_if.resp_ready_i = '1;
    drive_resp(0, 0, 0);
    do_reset();

    // alternating grants, distinct IDs
    n0 = 0; n1 = 1;
    for (int c = 0; c < 4; c++) begin
      drive_req(0, 1, n0, 64'h1000 + 64'(n0), 8'd3);
      drive_req(1, 1, n1, 64'h2000 + 64'(n1), 8'd1);
      settle();
      chk("t1_grant", 64'(bus_if.req_ready_o), (c % 2 == 0) ? 64'd1 : 64'd2);
      if (c > 0) chk("t1_mem_id", 64'(bus_if.mem_req_id_o), 64'(c - 1));
      tick();
      if (c % 2 == 0) n0 += 2; else n1 += 2;
    end

    // credit exhaustion for req0, req1 still served, retire frees a credit
    drive_req(1, 0, 0, 0, 0);
    for (int c = 0; c < 2; c++) begin
      drive_req(0, 1, n0, 64'h1000 + 64'(n0), 8'd3);
      settle();
      chk("t2_grant0", 64'(bus_if.req_ready_o), 64'd1);
      tick();
      n0 += 2;
    end
    drive_req(0, 1, 8, 64'h1008, 8'd0);
    settle();
    chk("t2_stall", 64'(bus_if.req_ready_o), 64'd0);
    chk("t2_cnt0_full", 64'(dut_cnt(0)), 64'd4);
    tick();
    drive_req(1, 1, 9, 64'h2009, 8'd0);
    settle();
    chk("t2_req1_granted", 64'(bus_if.req_ready_o), 64'd2);
    tick();
    drive_req(1, 0, 0, 0, 0);
    drive_resp(1, 2, 1);
    settle();
    chk("t2_resp_to_req0", 64'(bus_if.resp_valid_o), 64'd1);
    chk("t2_still_stalled", 64'(bus_if.req_ready_o), 64'd0);
    tick();
    drive_resp(0, 0, 0);
    settle();
    chk("t2_regrant", 64'(bus_if.req_ready_o), 64'd1);
    chk("t2_cnt0_after_retire", 64'(dut_cnt(0)), 64'd3);
    tick();
    drive_req(0, 0, 0, 0, 0);

    // 4-beat response to req1 on ID1 with owner back-pressure on beat 2
    drive_resp(1, 1, 0);
    settle();
    chk("t5_beat1_steer", 64'(bus_if.resp_valid_o), 64'd2);
    tick();
    bus_if.resp_ready_i = 2'b01;
    settle();
    chk("t5_backpressure", 64'(bus_if.mem_resp_ready_o), 64'd0);
    tick();
    bus_if.resp_ready_i = 2'b11;
    settle(); tick();
    settle(); tick();
    drive_resp(1, 1, 1);
    settle();
    chk("t5_cnt1_before_last", 64'(dut_cnt(1)), 64'd3);
    tick();
    drive_resp(0, 0, 0);
    settle();
    chk("t5_cnt1_after_last", 64'(dut_cnt(1)), 64'd2);
    tick();

    // unknown ID: consumed, not steered, sticky error; then reset mid-burst
    drive_resp(1, 12, 1);
    settle();
    chk("t6_no_steer", 64'(bus_if.resp_valid_o), 64'd0);
    chk("t6_consumed", 64'(bus_if.mem_resp_ready_o), 64'd1);
    tick();
    drive_resp(0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      settle();
      chk("t6_err_sticky", 64'(err), 64'd1);
      tick();
    end
    drive_resp(1, 0, 0);
    settle(); tick();
    do_reset();
    drive_resp(0, 0, 0);

    // same ID presented by both requesters
    drive_req(0, 1, 5, 64'hA5, 8'd2);
    drive_req(1, 1, 5, 64'hB5, 8'd2);
    settle();
    chk("t3_winner", 64'(bus_if.req_ready_o), 64'd1);
    tick();
    drive_req(0, 0, 0, 0, 0);
    settle();
    chk("t3_loser_blocked", 64'(bus_if.req_ready_o), 64'd0);
    chk("t3_mem_addr", bus_if.mem_req_addr_o, 64'hA5);
    tick();
    drive_resp(1, 5, 1);
    settle();
    chk("t3_retire_steer", 64'(bus_if.resp_valid_o), 64'd1);
    tick();
    drive_resp(0, 0, 0);
    settle();
    chk("t3_loser_granted", 64'(bus_if.req_ready_o), 64'd2);
    tick();
    drive_req(1, 0, 0, 0, 0);

    // adapter back-pressure holds the output register
    drive_req(0, 1, 7, 64'hC7, 8'd4);
    bus_if.mem_req_ready_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      settle();
      chk("t4_no_grant", 64'(bus_if.req_ready_o), 64'd0);
      chk("t4_hold_addr", bus_if.mem_req_addr_o, 64'hB5);
      tick();
    end
    bus_if.mem_req_ready_i = 1'b1;
    settle();
    chk("t4_grant_on_ready", 64'(bus_if.req_ready_o), 64'd1);
    tick();
    drive_req(0, 0, 0, 0, 0);
    do_reset();

    // random traffic
    for (int cyc = 0; cyc < 2000; cyc++) begin
      int pick, uid;
      for (int i = 0; i < N_REQ; i++)
        drive_req(i, $urandom_range(0, 3) != 0, $urandom_range(0, N_ID - 1),
                  {$urandom, $urandom}, 8'($urandom));
      bus_if.mem_req_ready_i = $urandom_range(0, 9) < 7;
      for (int i = 0; i < N_REQ; i++) bus_if.resp_ready_i[i] = $urandom_range(0, 9) < 8;
      if (!ra_active && rq.size() > 0 && $urandom_range(0, 1) == 1) begin
        pick = $urandom_range(0, rq.size() - 1);
        ra_id = rq[pick];
        rq.delete(pick);
        ra_beats = $urandom_range(1, 4);
        ra_active = 1;
      end
      if (ra_active) begin
        drive_resp($urandom_range(0, 3) != 0, ra_id, ra_beats == 1);
      end else begin
        uid = $urandom_range(0, N_ID - 1);
        if (cyc > 1500 && !m_busy[uid] && $urandom_range(0, 49) == 0) drive_resp(1, uid, 1);
        else drive_resp(0, uid, $urandom_range(0, 1));
      end
      settle();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
